// File: rtl/adc_spi_intf_if.sv
// Conversion handshake between the slider interface (initiator) and the ADC SPI responder.
`timescale 1ns/1ps
interface adc_spi_intf_if;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [11:0] res;
  logic        cnv_cmplt;

  modport master (output strt_cnv, output chnnl, input res, input cnv_cmplt);
  modport slave  (input strt_cnv, input chnnl, output res, output cnv_cmplt);
endinterface

// File: rtl/adc_spi_intf.sv
// Runs two 16-bit SPI frames to an 8-channel 12-bit ADC per request and returns the
// second frame's 12-bit result with a one-cycle cnv_cmplt pulse.
`timescale 1ns/1ps
module adc_spi_intf #(
  parameter int SCLK_DIV = 32,
  parameter int CS_GAP   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  adc_spi_intf_if.slave hs,
  output logic          SS_n,
  output logic          SCLK,
  output logic          MOSI,
  input  logic          MISO
);
  localparam int HALF  = SCLK_DIV / 2;
  localparam int PH_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  // Half-period slots: 0 front porch, 1..32 SCLK low/high halves, 33 back porch.
  localparam logic [5:0]       HP_LAST  = 6'd33;

  typedef enum logic [2:0] {IDLE, FRM1, GAP1, FRM2, GAP2, DONE} state_t;

  state_t            state_reg;
  logic [2:0]        ch_reg;
  logic [15:0]       cmd_reg;
  logic [11:0]       shift_reg;
  logic [PH_W-1:0]   ph_reg;
  logic [5:0]        hp_reg;
  logic [GAP_W-1:0]  gap_reg;
  logic [5:0]        hp_next;

  assign hp_next = hp_reg + 6'd1;
  // The command shifts out of the top bit; it is zero whenever no frame is active.
  assign MOSI    = cmd_reg[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ch_reg       <= '0;
      cmd_reg      <= '0;
      shift_reg    <= '0;
      ph_reg       <= '0;
      hp_reg       <= '0;
      gap_reg      <= '0;
      SS_n         <= 1'b1;
      SCLK         <= 1'b1;
      hs.res       <= '0;
      hs.cnv_cmplt <= 1'b0;
    end else begin
      hs.cnv_cmplt <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (hs.strt_cnv) begin
            ch_reg    <= hs.chnnl;
            cmd_reg   <= {2'b00, hs.chnnl, 11'h000};
            shift_reg <= '0;
            ph_reg    <= '0;
            hp_reg    <= '0;
            SS_n      <= 1'b0;
            SCLK      <= 1'b1;
            state_reg <= FRM1;
          end
        end
        FRM1, FRM2: begin
          if (ph_reg != PH_LAST) begin
            ph_reg <= ph_reg + 1'b1;
          end else begin
            ph_reg <= '0;
            if (hp_reg == HP_LAST) begin
              SS_n      <= 1'b1;
              SCLK      <= 1'b1;
              cmd_reg   <= '0;
              gap_reg   <= '0;
              state_reg <= (state_reg == FRM1) ? GAP1 : GAP2;
            end else begin
              hp_reg <= hp_next;
              SCLK   <= !(hp_next[0] && (hp_next != HP_LAST));
              // Falls after the first advance MOSI; every rise samples MISO.
              if (hp_next[0] && (hp_next >= 6'd3) && (hp_next != HP_LAST))
                cmd_reg <= {cmd_reg[14:0], 1'b0};
              if (!hp_next[0])
                shift_reg <= {shift_reg[10:0], MISO};
            end
          end
        end
        GAP1, GAP2: begin
          if (gap_reg != GAP_LAST) begin
            gap_reg <= gap_reg + 1'b1;
          end else if (state_reg == GAP1) begin
            cmd_reg   <= {2'b00, ch_reg, 11'h000};
            shift_reg <= '0;
            ph_reg    <= '0;
            hp_reg    <= '0;
            SS_n      <= 1'b0;
            SCLK      <= 1'b1;
            state_reg <= FRM2;
          end else begin
            hs.res       <= shift_reg;
            hs.cnv_cmplt <= 1'b1;
            state_reg    <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_spi_intf.sv
// Scoreboarded bench: ADC behavioural model, conversion result/timing checks, reset abort, small-divider instance.
`timescale 1ns/1ps
module tb_adc_spi_intf;
  localparam int DIV    = 32;
  localparam int GAP    = 8;
  localparam int F      = 17 * DIV;
  localparam int OP_LAT = 2 * F + 2 * GAP;
  localparam int OP_PER = OP_LAT + 2;

  typedef struct { logic [11:0] res; int cyc; } sb_t;
  typedef struct { logic [2:0] ch; logic [11:0] data; logic [15:0] cmd; } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ss_n, sclk, mosi;
  logic miso = 1'b0;
  logic ss_n_s, sclk_s, mosi_s;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int e0;
  sb_t sb_q[$];
  sb_t sb_e;
  logic [15:0] cmd_q[$];
  logic [15:0] exp_cmd;
  logic [11:0] adc_mem [8];
  vec_t vecs [6];

  logic [15:0] tx = '0;
  logic [15:0] rx = '0;
  int falls = 0;
  logic [2:0] prev_addr = '0;
  logic ss_prev = 1'b1;
  logic sclk_prev = 1'b1;

  adc_spi_intf_if hs();
  adc_spi_intf_if hs_s();

  adc_spi_intf #(.SCLK_DIV(DIV), .CS_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .hs(hs.slave),
    .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi), .MISO(miso)
  );

  adc_spi_intf #(.SCLK_DIV(4), .CS_GAP(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .hs(hs_s.slave),
    .SS_n(ss_n_s), .SCLK(sclk_s), .MOSI(mosi_s), .MISO(1'b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ADC model: answers with data for the address received in the previous frame.
  always @(ss_n or sclk) begin
    if (rst_n) begin
      if (ss_prev && !ss_n) begin
        tx = {4'h0, adc_mem[prev_addr]};
        rx = '0;
        falls = 0;
      end else if (!ss_prev && ss_n) begin
        prev_addr = rx[13:11];
        if (cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=%h required=none", rx);
        end else begin
          exp_cmd = cmd_q.pop_front();
          chk("frame_mosi", 32'(rx), 32'(exp_cmd));
          chk("frame_sclk_falls", falls, 16);
        end
      end else if (!ss_n && sclk_prev && !sclk) begin
        miso = tx[15];
        tx = {tx[14:0], 1'b0};
        falls++;
      end else if (!ss_n && !sclk_prev && sclk) begin
        rx = {rx[14:0], mosi};
      end
    end
    ss_prev = ss_n;
    sclk_prev = sclk;
  end

  always @(posedge clk) begin
    #1;
    if (hs.cnv_cmplt) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cnv_cmplt actual=res %h at cycle %0d required=no pulse", hs.res, cyc);
      end else begin
        sb_e = sb_q.pop_front();
        chk("res", 32'(hs.res), 32'(sb_e.res));
        chk("cnv_cmplt_cycle", cyc, sb_e.cyc);
        $display("op cyc=%0d res=%h expected_res=%h expected_cyc=%0d", cyc, hs.res, sb_e.res, sb_e.cyc);
      end
    end
  end

  task automatic push_op(input logic [11:0] res, input logic [15:0] cmd, input int start);
    sb_t e;
    e.res = res;
    e.cyc = start + OP_LAT;
    sb_q.push_back(e);
    cmd_q.push_back(cmd);
    cmd_q.push_back(cmd);
  endtask

  task automatic start_pulse(input logic [2:0] ch, output int start);
    hs.chnnl = ch;
    hs.strt_cnv = 1'b1;
    @(posedge clk); #1;
    start = cyc;
    hs.strt_cnv = 1'b0;
  endtask

  task automatic wait_pulse(input int max_cyc);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!hs.cnv_cmplt && n < max_cyc);
    if (!hs.cnv_cmplt) begin
      checks++;
      errors++;
      $display("FAIL timeout_cnv_cmplt actual=no pulse in %0d cycles required=pulse", n);
    end
  endtask

  task automatic chk_idle_pins(input string tag);
    chk({tag, "_ss_n"}, 32'(ss_n), 1);
    chk({tag, "_sclk"}, 32'(sclk), 1);
    chk({tag, "_mosi"}, 32'(mosi), 0);
  endtask

  initial begin
    int ss_low, sclk_low, first_low, run, n;
    bit got;
    vecs[0] = '{3'd0, 12'h000, 16'h0000};
    vecs[1] = '{3'd1, 12'h111, 16'h0800};
    vecs[2] = '{3'd2, 12'h222, 16'h1000};
    vecs[3] = '{3'd3, 12'h333, 16'h1800};
    vecs[4] = '{3'd4, 12'h444, 16'h2000};
    vecs[5] = '{3'd7, 12'h777, 16'h3800};
    for (int i = 0; i < 8; i++) adc_mem[i] = 12'h100 + 12'(i);
    adc_mem[2] = 12'hA5C;
    hs.strt_cnv = 1'b0;
    hs.chnnl = 3'd0;
    hs_s.strt_cnv = 1'b0;
    hs_s.chnnl = 3'd0;

    // Reset state and quiet idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk_idle_pins("reset");
    chk("reset_res", 32'(hs.res), 0);
    chk("reset_cnv_cmplt", 32'(hs.cnv_cmplt), 0);
    chk("reset_small_ss_n", 32'(ss_n_s), 1);
    chk("reset_small_sclk", 32'(sclk_s), 1);
    rst_n = 1'b1;
    repeat (50) @(posedge clk); #1;
    chk_idle_pins("idle");

    // Single request, channel 2
    start_pulse(3'd2, e0);
    push_op(12'hA5C, 16'h1000, e0);
    wait_pulse(OP_LAT + 10);
    @(posedge clk); #1;
    chk("pulse_width", 32'(hs.cnv_cmplt), 0);
    chk("res_hold", 32'(hs.res), 32'h A5C);
    repeat (3) @(posedge clk); #1;

    // Channel 7 with chnnl changed mid-operation
    start_pulse(3'd7, e0);
    push_op(12'h107, 16'h3800, e0);
    repeat (10) @(posedge clk); #1;
    hs.chnnl = 3'd0;
    wait_pulse(OP_LAT + 10);
    repeat (3) @(posedge clk); #1;

    // Back-to-back with strt_cnv held, channel advanced on each cnv_cmplt
    for (int c = 0; c < 8; c++) adc_mem[c] = 12'(c * 32'h111);
    hs.chnnl = vecs[0].ch;
    hs.strt_cnv = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    push_op(vecs[0].data, vecs[0].cmd, e0);
    for (int i = 1; i < 6; i++) begin
      wait_pulse(OP_PER + 10);
      hs.chnnl = vecs[i].ch;
      push_op(vecs[i].data, vecs[i].cmd, e0 + i * OP_PER);
    end
    wait_pulse(OP_PER + 10);
    hs.strt_cnv = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk_idle_pins("after_b2b");

    // Reset in the middle of the second frame
    start_pulse(3'd5, e0);
    push_op(12'h555, 16'h2800, e0);
    repeat (700) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_idle_pins("abort");
    chk("abort_res", 32'(hs.res), 0);
    chk("abort_cnv_cmplt", 32'(hs.cnv_cmplt), 0);
    sb_q.delete();
    cmd_q.delete();
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk); #1;
    chk_idle_pins("post_abort");
    start_pulse(3'd5, e0);
    push_op(12'h555, 16'h2800, e0);
    wait_pulse(OP_LAT + 10);
    repeat (3) @(posedge clk); #1;

    // Minimum divider and gap: SCLK_DIV=4, CS_GAP=1, MISO tied high
    hs_s.chnnl = 3'd3;
    hs_s.strt_cnv = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    hs_s.strt_cnv = 1'b0;
    ss_low = 0; sclk_low = 0; first_low = 0; run = 0; n = 0; got = 1'b0;
    while (!got && n < 200) begin
      if (!ss_n_s) ss_low++;
      if (!sclk_s) begin
        sclk_low++;
        run++;
      end else begin
        if (run > 0 && first_low == 0) first_low = run;
        run = 0;
      end
      if (hs_s.cnv_cmplt) begin
        got = 1'b1;
        chk("small_cnv_cycle", cyc, e0 + 138);
        chk("small_res", 32'(hs_s.res), 32'hFFF);
        $display("op small cyc=%0d res=%h", cyc, hs_s.res);
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("small_pulse_seen", 32'(got), 1);
    chk("small_ss_low_cycles", ss_low, 136);
    chk("small_sclk_low_cycles", sclk_low, 64);
    chk("small_sclk_half_period", first_low, 2);

    repeat (10) @(posedge clk); #1;
    chk("final_res_hold", 32'(hs.res), 32'h555);
    chk("scoreboard_empty", sb_q.size(), 0);
    chk("frame_queue_empty", cmd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
